ddr_rx_deserializer: RTL and testbench
======================================

Name: ddr_rx_deserializer

Overview:
- Parametrised HDR-DDR receive deserializer. Successor to the single-mode byte RX.
- Samples SDA on both SCL edges, using the pos/neg edge strobes from scl_generation.
- Assembles preamble, data words with parity, and CRC words. Runs the CRC-5 check in-line.
- Sits between sda_handling/scl_generation and the DDR CCC controller.

Parameters:
- WORD_BITS, 16: data bits per DDR data word. Must be even.
- PAR_BITS, 2: parity bits following each data word. Fixed at 2.
- TOKEN_BITS, 4: CRC-word token width.
- CRC_TOKEN, 4'hC: expected token value.
- CRC_BITS, 5: CRC width.
- CRC_SEED, 5'h1F: running CRC seed.

Ports:
- i_sys_clk  in  1  system clock
- i_sys_rst  in  1  asynchronous active-low reset
- i_sclgen_scl_pos_edge  in  1  one-cycle strobe: SCL rising edge
- i_sclgen_scl_neg_edge  in  1  one-cycle strobe: SCL falling edge
- i_sdahnd_rx_sda  in  1  SDA line value
- i_ddrccc_rx_en  in  1  receive enable
- i_ddrccc_rx_mode  in  2  0 NONE, 1 PREAMBLE, 2 DATA_WORD, 3 CRC_WORD
- i_ddrccc_crc_init  in  1  one-cycle pulse: load CRC_SEED into running CRC
- o_regfcrc_rx_data_out  out  WORD_BITS  last received data word
- o_ddrccc_pre  out  2  last received preamble bits
- o_ddrccc_rx_mode_done  out  1  one-cycle pulse: current mode's field complete
- o_ddrccc_error  out  1  one-cycle pulse with done: parity, token or CRC mismatch
- o_rx_crc  out  CRC_BITS  current running CRC value

Behaviour:
- Reset values: all outputs 0; o_rx_crc = CRC_SEED; FSM in IDLE; bit counter 0.
- Sample event = enable high AND (pos_edge OR neg_edge). Both strobes in one cycle count as one sample.
- Shift order: MSB first into the shift register.
- Field lengths: PREAMBLE 2 bits; DATA_WORD WORD_BITS+PAR_BITS bits; CRC_WORD TOKEN_BITS+CRC_BITS bits; NONE never starts.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT: en=1, mode≠0 and a sample event. That first sample is captured as bit 0.
- SHIFT -> DONE: the sample event of the last bit of the field.
- DONE: asserts done (and error if applicable) for exactly one cycle, updates outputs, then returns to IDLE.
- Latency: done is high in the cycle after the last-bit sample.
- Back-to-back fields: a sample event in the DONE cycle is not lost; it is taken as bit 0 of the next field, so DONE -> SHIFT directly.
- Abort: en falls or the mode changes while in SHIFT → return to IDLE next cycle, clear the counter, no done and no error. Running CRC keeps the bits already shifted.
- PREAMBLE: o_ddrccc_pre = {first bit, second bit}. Error never asserted.
- DATA_WORD data bits:
  - The WORD_BITS data bits go to o_regfcrc_rx_data_out at DONE.
  - Each data bit also feeds the serial CRC as it is sampled: fb = crc[4]^bit; crc = {crc[3:0],0} ^ (fb ? 5'b00101 : 0), i.e. x^5+x^2+1.
  - Parity bits do not feed the CRC.
- DATA_WORD parity:
  - Expected PA1 = XOR of odd-index data bits; PA0 = XOR of even-index data bits XOR 1.
  - Received {PA1,PA0} are the last 2 bits.
  - Mismatch → error pulse. Data is still updated.
- CRC_WORD:
  - The first TOKEN_BITS must equal CRC_TOKEN, and the next CRC_BITS must equal the running CRC sampled at the start of the word. Either mismatch → error.
  - o_regfcrc_rx_data_out is unchanged.
- CRC init:
  - i_ddrccc_crc_init loads CRC_SEED next cycle.
  - If it coincides with a data-bit sample, the init wins and that bit is not folded.
- Reset mid-operation: asynchronously returns everything to reset values.

Decomposition:
- Shared package ddr_rx_pkg holds:
  - mode encodings RX_MODE_NONE/PREAMBLE/DATA/CRC
  - FSM state encodings
  - CRC_POLY = 5'b00101, CRC_SEED, CRC_TOKEN
  - field-length constants derived from the parameters
- One sub-module, ddr_crc5_serial: seed load, enable, serial data in, CRC out. Also reusable by the TX side.

Test Plan:
1. Reset → all outputs 0, o_rx_crc=5'h1F; toggling SCL strobes with en=0 → no done.
2. Preamble: en=1, mode=1, SDA 0 then 1 on consecutive edges → done one cycle after the 2nd sample, o_ddrccc_pre=2'b01, error=0.
3. Data word: crc_init, then mode=2 with 16'h0000 + parity 01 → data_out=16'h0000, error=0, o_rx_crc=5'h01.
4. Parity error: 16'h0001 + parity 01 (expected 00) → done and error both pulse, data_out=16'h0001.
5. CRC word after scenario 3: mode=3, bits 1100_00001 → done, error=0. Repeat with CRC 00010 → error=1. Repeat with token 1010 → error=1.
6. Abort and back-to-back:
   - Drop en after 7 data bits → no done; a following full word is received correctly.
   - Two data words on consecutive edges → two done pulses, second word intact.

Source files
------------

// File: rtl/ddr_rx_pkg.sv
// Shared encodings and constants for the HDR-DDR receive path.
package ddr_rx_pkg;

  localparam logic [1:0] RX_MODE_NONE     = 2'd0;
  localparam logic [1:0] RX_MODE_PREAMBLE = 2'd1;
  localparam logic [1:0] RX_MODE_DATA     = 2'd2;
  localparam logic [1:0] RX_MODE_CRC      = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int         CRC_W     = 5;
  localparam logic [4:0] CRC_POLY  = 5'b00101;
  localparam logic [4:0] CRC_SEED  = 5'h1F;
  localparam logic [3:0] CRC_TOKEN = 4'hC;

  localparam int DEF_WORD_BITS  = 16;
  localparam int DEF_PAR_BITS   = 2;
  localparam int DEF_TOKEN_BITS = 4;

  localparam int PRE_LEN  = 2;
  localparam int DATA_LEN = DEF_WORD_BITS + DEF_PAR_BITS;
  localparam int CRCW_LEN = DEF_TOKEN_BITS + CRC_W;

endpackage

// File: rtl/ddr_crc5_serial.sv
// Bit-serial Galois CRC (x^5+x^2+1 by default), MSB first; shared by RX and TX.
module ddr_crc5_serial
  import ddr_rx_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = ddr_rx_pkg::CRC_POLY,
  parameter logic [WIDTH-1:0] SEED  = ddr_rx_pkg::CRC_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] crc
);

  logic fb;

  assign fb = crc[WIDTH-1] ^ din;

  // Seed load has priority so a coincident data bit is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      crc <= SEED;
    else if (load)
      crc <= SEED;
    else if (en)
      crc <= {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

endmodule

// File: rtl/ddr_rx_deserializer.sv
// HDR-DDR receive deserializer: samples SDA on both SCL edges and assembles
// preamble, parity-protected data words and CRC words with in-line checking.
module ddr_rx_deserializer
  import ddr_rx_pkg::*;
#(
  parameter int                    WORD_BITS  = 16,
  parameter int                    PAR_BITS   = 2,
  parameter int                    TOKEN_BITS = 4,
  parameter logic [TOKEN_BITS-1:0] CRC_TOKEN  = ddr_rx_pkg::CRC_TOKEN,
  parameter int                    CRC_BITS   = 5,
  parameter logic [CRC_BITS-1:0]   CRC_SEED   = ddr_rx_pkg::CRC_SEED
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst,
  input  logic                 i_sclgen_scl_pos_edge,
  input  logic                 i_sclgen_scl_neg_edge,
  input  logic                 i_sdahnd_rx_sda,
  input  logic                 i_ddrccc_rx_en,
  input  logic [1:0]           i_ddrccc_rx_mode,
  input  logic                 i_ddrccc_crc_init,
  output logic [WORD_BITS-1:0] o_regfcrc_rx_data_out,
  output logic [1:0]           o_ddrccc_pre,
  output logic                 o_ddrccc_rx_mode_done,
  output logic                 o_ddrccc_error,
  output logic [CRC_BITS-1:0]  o_rx_crc
);

  localparam int D_LEN = WORD_BITS + PAR_BITS;
  localparam int C_LEN = TOKEN_BITS + CRC_BITS;
  localparam int SH_W  = (D_LEN > C_LEN) ? D_LEN : C_LEN;
  localparam int CNT_W = $clog2(SH_W + 1);

  function automatic logic [1:0] parity_of(input logic [WORD_BITS-1:0] w);
    logic pa1;
    logic pa0;
    pa1 = 1'b0;
    pa0 = 1'b1;
    for (int i = 0; i < WORD_BITS; i++) begin
      if (i % 2 == 1) pa1 ^= w[i];
      else            pa0 ^= w[i];
    end
    return {pa1, pa0};
  endfunction

  logic [1:0]           state;
  logic [1:0]           cur_mode;
  logic [1:0]           fmode;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     idx;
  logic [CNT_W-1:0]     flen;
  logic [SH_W-2:0]      sh;
  logic [SH_W-1:0]      field;
  logic [WORD_BITS-1:0] word;
  logic [CRC_BITS-1:0]  crc;
  logic [CRC_BITS-1:0]  crc_snap;
  logic                 sample;
  logic                 start;
  logic                 abort;
  logic                 take;
  logic                 last;
  logic                 crc_en;
  logic                 field_err;

  assign sample = i_ddrccc_rx_en & (i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge);
  assign start  = sample && (i_ddrccc_rx_mode != RX_MODE_NONE) && (state != ST_SHIFT);
  assign abort  = (state == ST_SHIFT) && (!i_ddrccc_rx_en || (i_ddrccc_rx_mode != cur_mode));
  assign take   = start || ((state == ST_SHIFT) && !abort && sample);
  assign fmode  = start ? i_ddrccc_rx_mode : cur_mode;
  assign idx    = start ? '0 : cnt;
  assign last   = take && (idx == flen - CNT_W'(1));
  assign field  = {sh, i_sdahnd_rx_sda};
  assign word   = field[D_LEN-1:PAR_BITS];
  assign crc_en = take && (fmode == RX_MODE_DATA) && (idx < CNT_W'(WORD_BITS));

  always_comb begin
    flen      = CNT_W'(PRE_LEN);
    field_err = 1'b0;
    case (fmode)
      RX_MODE_DATA: begin
        flen      = CNT_W'(D_LEN);
        field_err = (field[1:0] != parity_of(word));
      end
      RX_MODE_CRC: begin
        flen      = CNT_W'(C_LEN);
        field_err = (field[C_LEN-1:CRC_BITS] != CRC_TOKEN) ||
                    (field[CRC_BITS-1:0] != crc_snap);
      end
      default: ;
    endcase
  end

  ddr_crc5_serial #(
    .WIDTH (CRC_BITS),
    .SEED  (CRC_SEED)
  ) u_crc (
    .clk   (i_sys_clk),
    .rst_n (i_sys_rst),
    .load  (i_ddrccc_crc_init),
    .en    (crc_en),
    .din   (i_sdahnd_rx_sda),
    .crc   (crc)
  );

  assign o_rx_crc = crc;

  // Field sequencing; outputs are registered on the last-bit sample so they
  // are valid in the same cycle as the done pulse.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state                 <= ST_IDLE;
      cur_mode              <= RX_MODE_NONE;
      cnt                   <= '0;
      o_ddrccc_rx_mode_done <= 1'b0;
      o_ddrccc_error        <= 1'b0;
      o_regfcrc_rx_data_out <= '0;
      o_ddrccc_pre          <= '0;
    end else begin
      o_ddrccc_rx_mode_done <= last;
      o_ddrccc_error        <= last && field_err;
      if (abort) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (take) begin
        cur_mode <= fmode;
        if (last) begin
          state <= ST_DONE;
          cnt   <= '0;
        end else begin
          state <= ST_SHIFT;
          cnt   <= idx + CNT_W'(1);
        end
      end else if (state == ST_DONE) begin
        state <= ST_IDLE;
      end
      if (last && (fmode == RX_MODE_DATA))
        o_regfcrc_rx_data_out <= word;
      if (last && (fmode == RX_MODE_PREAMBLE))
        o_ddrccc_pre <= field[1:0];
    end
  end

  // Datapath: shift register and CRC snapshot taken at the start of a CRC word.
  always_ff @(posedge i_sys_clk) begin
    if (take)
      sh <= field[SH_W-2:0];
    if (start && (i_ddrccc_rx_mode == RX_MODE_CRC))
      crc_snap <= crc;
  end

endmodule

// File: tb/tb_ddr_rx_deserializer.sv
// Bench for ddr_rx_deserializer: directed vector table, corner sequences and
// randomized fields against a field-level reference model.
module tb_ddr_rx_deserializer;

  localparam logic [1:0] M_PRE  = 2'd1;
  localparam logic [1:0] M_DATA = 2'd2;
  localparam logic [1:0] M_CRC  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pos;
  logic        neg;
  logic        sda;
  logic        en;
  logic        crc_init;
  logic [1:0]  mode;
  logic [15:0] data_out;
  logic [1:0]  pre;
  logic        done;
  logic        err;
  logic [4:0]  rx_crc;

  int checks   = 0;
  int failures = 0;

  logic [4:0]  m_crc;
  logic [15:0] m_data;
  logic [1:0]  m_pre;

  typedef struct {
    string       nm;
    bit          init;
    logic [1:0]  md;
    logic [31:0] bits;
    bit          e_err;
    logic [15:0] e_data;
    logic [1:0]  e_pre;
    logic [4:0]  e_crc;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  ddr_rx_deserializer dut (
    .i_sys_clk             (clk),
    .i_sys_rst             (rst_n),
    .i_sclgen_scl_pos_edge (pos),
    .i_sclgen_scl_neg_edge (neg),
    .i_sdahnd_rx_sda       (sda),
    .i_ddrccc_rx_en        (en),
    .i_ddrccc_rx_mode      (mode),
    .i_ddrccc_crc_init     (crc_init),
    .o_regfcrc_rx_data_out (data_out),
    .o_ddrccc_pre          (pre),
    .o_ddrccc_rx_mode_done (done),
    .o_ddrccc_error        (err),
    .o_rx_crc              (rx_crc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Remainder of a GF(2) polynomial modulo x^5+x^2+1.
  function automatic logic [4:0] gf_mod(input logic [63:0] v);
    logic [63:0] r;
    r = v;
    for (int k = 63; k >= 5; k--)
      if (r[k]) r = r ^ (64'd37 << (k - 5));
    return r[4:0];
  endfunction

  // CRC register after n message bits m (MSB first) starting from c.
  function automatic logic [4:0] crc_after(input logic [4:0] c, input logic [31:0] m, input int n);
    return gf_mod((64'(c) << n) ^ (64'(m) << 5));
  endfunction

  function automatic logic [1:0] exp_par(input logic [15:0] w);
    int odd_ones;
    int even_ones;
    odd_ones  = 0;
    even_ones = 0;
    for (int i = 0; i < 16; i++)
      if (i % 2 == 1) odd_ones += int'(w[i]);
      else            even_ones += int'(w[i]);
    return {1'(odd_ones % 2), 1'((even_ones + 1) % 2)};
  endfunction

  function automatic int field_len(input logic [1:0] md);
    return (md == M_PRE) ? 2 : (md == M_DATA) ? 18 : 9;
  endfunction

  task automatic model_field(input logic [1:0] md, input logic [31:0] bits, input int init_at,
                             output bit e_err);
    logic [15:0] w;
    int          rem;
    e_err = 1'b0;
    case (md)
      M_PRE: m_pre = bits[1:0];
      M_DATA: begin
        w      = bits[17:2];
        e_err  = (bits[1:0] != exp_par(w));
        m_data = w;
        if (init_at >= 0 && init_at < 16) begin
          rem   = 15 - init_at;
          m_crc = crc_after(5'h1F, 32'(w) & ((32'd1 << rem) - 32'd1), rem);
        end else begin
          m_crc = crc_after(m_crc, 32'(w), 16);
        end
      end
      M_CRC: e_err = (bits[8:5] != 4'hC) || (bits[4:0] != m_crc);
      default: ;
    endcase
  endtask

  task automatic send_bits(input logic [1:0] md, input logic [31:0] bits, input int n,
                           input int init_at, output bit early);
    int r;
    early = 1'b0;
    mode  = md;
    en    = 1'b1;
    for (int p = 0; p < n; p++) begin
      r        = int'($urandom_range(0, 2));
      sda      = bits[n-1-p];
      pos      = (r != 1);
      neg      = (r != 0);
      crc_init = (p == init_at);
      @(posedge clk); #1;
      pos      = 1'b0;
      neg      = 1'b0;
      crc_init = 1'b0;
      if (p < n - 1 && done) early = 1'b1;
    end
  endtask

  task automatic field_check(input string nm, input logic [1:0] md, input logic [31:0] bits,
                             input int init_at, input bit idle_after, input bit e_err,
                             input logic [15:0] e_data, input logic [1:0] e_pre,
                             input logic [4:0] e_crc);
    bit early;
    send_bits(md, bits, field_len(md), init_at, early);
    chk({nm, ".early_done"}, 32'(early), 32'd0);
    chk({nm, ".done"}, 32'(done), 32'd1);
    chk({nm, ".error"}, 32'(err), 32'(e_err));
    chk({nm, ".data"}, 32'(data_out), 32'(e_data));
    chk({nm, ".pre"}, 32'(pre), 32'(e_pre));
    chk({nm, ".crc"}, 32'(rx_crc), 32'(e_crc));
    if (idle_after) begin
      @(posedge clk); #1;
      chk({nm, ".pulse_width"}, 32'({done, err}), 32'd0);
    end
  endtask

  task automatic do_field(input string nm, input logic [1:0] md, input logic [31:0] bits,
                          input int init_at, input bit idle_after);
    bit e_err;
    model_field(md, bits, init_at, e_err);
    field_check(nm, md, bits, init_at, idle_after, e_err, m_data, m_pre, m_crc);
  endtask

  task automatic pulse_init();
    crc_init = 1'b1;
    @(posedge clk); #1;
    crc_init = 1'b0;
    m_crc    = 5'h1F;
    chk("init.crc", 32'(rx_crc), 32'h1F);
  endtask

  initial begin
    bit          early;
    bit          e_err;
    logic [15:0] w;
    logic [31:0] bits;
    int          kind;

    tbl[0] = '{"pre01",      1'b0, M_PRE,  32'h00001, 1'b0, 16'h0000, 2'b01, 5'h01};
    tbl[0].e_crc = 5'h1F;
    tbl[1] = '{"data0",      1'b1, M_DATA, 32'h00001, 1'b0, 16'h0000, 2'b01, 5'h01};
    tbl[2] = '{"crc_ok",     1'b0, M_CRC,  32'h00181, 1'b0, 16'h0000, 2'b01, 5'h01};
    tbl[3] = '{"crc_badval", 1'b0, M_CRC,  32'h00182, 1'b1, 16'h0000, 2'b01, 5'h01};
    tbl[4] = '{"crc_badtok", 1'b0, M_CRC,  32'h00141, 1'b1, 16'h0000, 2'b01, 5'h01};
    tbl[5] = '{"data_parerr",1'b1, M_DATA, 32'h00005, 1'b1, 16'h0001, 2'b01, 5'h04};
    tbl[6] = '{"pre10",      1'b0, M_PRE,  32'h00002, 1'b0, 16'h0001, 2'b10, 5'h04};
    tbl[7] = '{"crc_ok2",    1'b0, M_CRC,  32'h00184, 1'b0, 16'h0001, 2'b10, 5'h04};

    rst_n = 1'b0; pos = 1'b0; neg = 1'b0; sda = 1'b0;
    en = 1'b0; crc_init = 1'b0; mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.error", 32'(err), 32'd0);
    chk("reset.data", 32'(data_out), 32'd0);
    chk("reset.pre", 32'(pre), 32'd0);
    chk("reset.crc", 32'(rx_crc), 32'h1F);
    rst_n  = 1'b1;
    m_crc  = 5'h1F;
    m_data = 16'h0;
    m_pre  = 2'b00;

    // strobes toggle with receive disabled
    mode  = M_DATA;
    early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pos = i[0];
      neg = ~i[0];
      sda = 1'($urandom);
      @(posedge clk); #1;
      if (done) early = 1'b1;
    end
    pos = 1'b0; neg = 1'b0;
    chk("en_low.no_done", 32'(early), 32'd0);
    chk("en_low.crc", 32'(rx_crc), 32'h1F);

    foreach (tbl[i]) begin
      if (tbl[i].init) pulse_init();
      model_field(tbl[i].md, tbl[i].bits, -1, e_err);
      field_check(tbl[i].nm, tbl[i].md, tbl[i].bits, -1, 1'b1, tbl[i].e_err,
                  tbl[i].e_data, tbl[i].e_pre, tbl[i].e_crc);
    end

    // enable drops after 7 data bits
    pulse_init();
    send_bits(M_DATA, 32'h5B, 7, -1, early);
    en = 1'b0;
    @(posedge clk); #1;
    chk("abort_en.no_done", 32'({early, done}), 32'd0);
    m_crc = crc_after(m_crc, 32'h5B, 7);
    chk("abort_en.crc", 32'(rx_crc), 32'(m_crc));
    chk("abort_en.data", 32'(data_out), 32'(m_data));
    w = 16'h1234;
    do_field("after_abort", M_DATA, {14'b0, w, exp_par(w)}, -1, 1'b1);

    // mode changes mid-word
    send_bits(M_DATA, 32'h16, 5, -1, early);
    mode = M_PRE;
    @(posedge clk); #1;
    chk("abort_mode.no_done", 32'({early, done, err}), 32'd0);
    m_crc = crc_after(m_crc, 32'h16, 5);
    chk("abort_mode.crc", 32'(rx_crc), 32'(m_crc));
    do_field("pre_after_modechg", M_PRE, 32'h3, -1, 1'b1);

    // two words on consecutive edges
    w = 16'hBEEF;
    do_field("b2b_first", M_DATA, {14'b0, w, exp_par(w)}, -1, 1'b0);
    w = 16'h0F0F;
    do_field("b2b_second", M_DATA, {14'b0, w, exp_par(w)}, -1, 1'b1);
    do_field("b2b_crc", M_CRC, {23'b0, 4'hC, m_crc}, -1, 1'b1);

    // CRC init coinciding with data bit 3
    w = 16'hC3A5;
    do_field("init_mid", M_DATA, {14'b0, w, exp_par(w)}, 3, 1'b1);

    // asynchronous reset in the middle of a word
    send_bits(M_DATA, 32'h15, 5, -1, early);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.outputs", 32'({done, err, pre, data_out}), 32'd0);
    chk("rst_mid.crc", 32'(rx_crc), 32'h1F);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    m_crc  = 5'h1F;
    m_data = 16'h0;
    m_pre  = 2'b00;
    do_field("pre_after_reset", M_PRE, 32'h2, -1, 1'b1);

    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) pulse_init();
      case (kind)
        1: bits = 32'($urandom_range(0, 3));
        2: begin
          w    = 16'($urandom);
          bits = {14'b0, w, exp_par(w) ^ (($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00)};
        end
        default: bits = ($urandom_range(0, 2) != 0) ? {23'b0, 4'hC, m_crc} : 32'($urandom_range(0, 511));
      endcase
      do_field($sformatf("rand%0d", it), 2'(kind), bits, -1, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
